// File: rtl/wdt_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_pkg
//  Description : Shared types and constants for the watchdog recovery
//                controller: FSM state encoding, register map, kick key,
//                STATUS field positions and a STATUS packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package wdt_pkg;

    // FSM state encoding; the value is visible to software in STATUS[1:0]
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RECOVER  = 2'd2,
        ST_FATAL    = 2'd3
    } wdt_state_t;

    // Register map (din_addr also selects the dout read source)
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LOAD   = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Only this exact word written to KICK counts as a valid kick
    localparam logic [31:0] KICK_KEY = 32'h600D_F00D;

    // STATUS field positions
    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_RETRIES_LSB = 4;
    localparam int STAT_FATAL_BIT   = 8;
    localparam int STAT_WARN_BIT    = 9;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] pack_status(input logic [1:0] st,
                                                input logic [3:0] retries,
                                                input logic       fat,
                                                input logic       wrn);
        logic [31:0] s;
        s                             = '0;
        s[STAT_STATE_LSB +: 2]        = st;
        s[STAT_RETRIES_LSB +: 4]      = retries;
        s[STAT_FATAL_BIT]             = fat;
        s[STAT_WARN_BIT]              = wrn;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wdt_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_recovery_ctrl_if
//  Description : Peripheral register bus of the watchdog recovery controller.
//                One-cycle write strobe, no back-pressure, registered read
//                data selected by din_addr.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wdt_recovery_ctrl_if;
    import wdt_pkg::*;

    logic        din_val;   // write strobe, one cycle per write
    logic [1:0]  din_addr;  // register select / read source select
    logic [31:0] din;       // write data
    logic [31:0] dout;      // registered read data

    // Bus master (CPU side)
    modport master (
        output din_val,
        output din_addr,
        output din,
        input  dout
    );

    // Watchdog side
    modport slave (
        input  din_val,
        input  din_addr,
        input  din,
        output dout
    );

endinterface
`default_nettype wire

// File: rtl/wdt_recovery_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_counter
//  Description : Loadable down-counter for the watchdog timeout. Load has
//                priority over decrement; decrement stops at zero so the
//                count can never wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module wdt_counter #(
    parameter int               WIDTH   = 24,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output      logic [WIDTH-1:0] count,
    output      logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: reload wins, otherwise saturating decrement
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wdt_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_recovery_ctrl
//  Description : Watchdog recovery controller. Software arms a loadable
//                down-counter and must kick it with KICK_KEY before expiry.
//                An expiry or a bad kick holds the guarded CPU in reset for
//                RESET_CYCLES cycles and re-arms; once MAX_RETRIES recoveries
//                have been used, the next timeout latches FATAL until resetn.
//                Optional feature macro: WDT_RECOVERY_PREWARN_EN enables the
//                registered pre-expiry warn output (counter < LOAD/4).
//  Revision    : 1.0 - initial release
// ============================================================================
module wdt_recovery_ctrl
    import wdt_pkg::*;
#(
    parameter int TIMEOUT_W       = 24,
    parameter int DEFAULT_TIMEOUT = 100000,
    parameter int RESET_CYCLES    = 16,
    parameter int MAX_RETRIES     = 3
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    wdt_recovery_ctrl_if.slave bus,
    output      logic          cpu_resetn,
    output      logic          fatal,
    output      logic          warn
);

    // Reset-window counter only needs to hold RESET_CYCLES-1
    localparam int                   c_rc_w      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_rc_w-1:0]    c_rc_init   = c_rc_w'(RESET_CYCLES - 1);
    localparam logic [3:0]           c_retry_max = 4'(MAX_RETRIES);
    localparam logic [TIMEOUT_W-1:0] c_load_rst  = TIMEOUT_W'(DEFAULT_TIMEOUT);

    wdt_state_t           r_state;
    wdt_state_t           w_state_nxt;
    logic [3:0]           r_retries;
    logic [3:0]           w_retries_nxt;
    logic [c_rc_w-1:0]    r_rc;
    logic [c_rc_w-1:0]    w_rc_nxt;
    logic [TIMEOUT_W-1:0] r_load;
    logic                 r_ctrl_en;
    logic                 r_cpu_resetn;
    logic [31:0]          r_dout;
    logic [31:0]          w_rd_data;
    logic                 w_warn;

    logic [TIMEOUT_W-1:0] w_count;
    logic                 w_zero;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;

    // Bus write decode; writes are only honoured in DISABLED and ARMED
    logic                 w_wr_ok;
    logic                 w_wr_ctrl;
    logic                 w_wr_load;
    logic                 w_wr_kick;
    logic                 w_kick_ok;
    logic                 w_kick_bad;
    logic [TIMEOUT_W-1:0] w_load_wdata;

    assign w_wr_ok    = (r_state == ST_DISABLED) || (r_state == ST_ARMED);
    assign w_wr_ctrl  = bus.din_val && (bus.din_addr == ADDR_CTRL) && w_wr_ok;
    assign w_wr_load  = bus.din_val && (bus.din_addr == ADDR_LOAD) && w_wr_ok;
    assign w_wr_kick  = bus.din_val && (bus.din_addr == ADDR_KICK) && (r_state == ST_ARMED);
    assign w_kick_ok  = w_wr_kick && (bus.din == KICK_KEY);
    assign w_kick_bad = w_wr_kick && (bus.din != KICK_KEY);

    // A zero timeout would expire immediately, so it is stored as 1
    assign w_load_wdata = (bus.din[TIMEOUT_W-1:0] == '0) ? TIMEOUT_W'(1)
                                                         : bus.din[TIMEOUT_W-1:0];

    wdt_counter #(
        .WIDTH   (TIMEOUT_W),
        .RST_VAL (c_load_rst)
    ) u_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_cnt_load),
        .load_val (r_load),
        .dec      (w_cnt_dec),
        .count    (w_count),
        .zero     (w_zero)
    );

    // FSM state, retry count and reset-window counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_DISABLED;
            r_retries <= 4'd0;
            r_rc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_retries <= w_retries_nxt;
            r_rc      <= w_rc_nxt;
        end
    end

    // Next-state logic and timeout-counter control
    always_comb begin
        w_state_nxt   = r_state;
        w_retries_nxt = r_retries;
        w_rc_nxt      = r_rc;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;

        case (r_state)
            ST_DISABLED: begin
                // Counter follows LOAD so arming starts from a fresh value
                w_cnt_load = 1'b1;
                if (w_wr_ctrl && bus.din[0]) begin
                    w_state_nxt = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (w_kick_ok) begin
                    // A valid kick wins even when the count is already zero
                    w_cnt_load = 1'b1;
                end else if (w_kick_bad || w_zero) begin
                    if (r_retries == c_retry_max) begin
                        w_state_nxt = ST_FATAL;
                    end else begin
                        w_retries_nxt = r_retries + 4'd1;
                        w_rc_nxt      = c_rc_init;
                        w_state_nxt   = ST_RECOVER;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                    if (w_wr_ctrl && !bus.din[0]) begin
                        w_state_nxt = ST_DISABLED;
                    end
                end
            end

            ST_RECOVER: begin
                if (r_rc == '0) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_rc_nxt = r_rc - c_rc_w'(1);
                end
            end

            ST_FATAL: begin
                // Terminal until resetn
            end

            default: begin
                w_state_nxt = ST_DISABLED;
            end
        endcase
    end

    // Software-visible CTRL and LOAD registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ctrl_en <= 1'b0;
            r_load    <= c_load_rst;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl_en <= bus.din[0];
            end
            if (w_wr_load) begin
                r_load <= w_load_wdata;
            end
        end
    end

    // CPU reset is low whenever the FSM is in RECOVER or FATAL
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cpu_resetn <= 1'b1;
        end else begin
            r_cpu_resetn <= (w_state_nxt == ST_DISABLED) || (w_state_nxt == ST_ARMED);
        end
    end

`ifdef WDT_RECOVERY_PREWARN_EN
    logic [TIMEOUT_W-1:0] w_cnt_nxt;
    logic                 r_warn;

    // Count value the counter will hold next cycle, so warn lines up with it
    assign w_cnt_nxt = w_cnt_load ? r_load :
                       (w_cnt_dec && !w_zero) ? (w_count - TIMEOUT_W'(1)) : w_count;

    // Pre-expiry warning: armed and below a quarter of the timeout
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= (w_state_nxt == ST_ARMED) && (w_cnt_nxt < (r_load >> 2));
        end
    end

    assign w_warn = r_warn;
`else
    assign w_warn = 1'b0;
`endif

    // Read mux; the registered copy appears on dout one cycle later
    always_comb begin
        w_rd_data = '0;
        case (bus.din_addr)
            ADDR_CTRL:   w_rd_data = {31'd0, r_ctrl_en};
            ADDR_LOAD:   w_rd_data = 32'(r_load);
            ADDR_KICK:   w_rd_data = 32'(w_count);
            ADDR_STATUS: w_rd_data = pack_status(r_state, r_retries, fatal, w_warn);
            default:     w_rd_data = '0;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rd_data;
        end
    end

    assign bus.dout   = r_dout;
    assign cpu_resetn = r_cpu_resetn;
    assign fatal      = (r_state == ST_FATAL);
    assign warn       = w_warn;

endmodule
`default_nettype wire

// File: tb/tb_wdt_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wdt_recovery_ctrl
//  Description : Directed self-checking bench for wdt_recovery_ctrl with the
//                default parameters (LOAD reset 100000, 16-cycle reset
//                window, 3 retries). Honours WDT_RECOVERY_PREWARN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_recovery_ctrl;
    import wdt_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic cpu_resetn;
    logic fatal;
    logic warn;

    int n_checks = 0;
    int n_fail   = 0;

    wdt_recovery_ctrl_if bus ();

    wdt_recovery_ctrl #(
        .TIMEOUT_W       (24),
        .DEFAULT_TIMEOUT (100000),
        .RESET_CYCLES    (16),
        .MAX_RETRIES     (3)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .cpu_resetn (cpu_resetn),
        .fatal      (fatal),
        .warn       (warn)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.din_val  = 1'b1;
        bus.din_addr = a;
        bus.din      = d;
        tick();
        bus.din_val  = 1'b0;
        bus.din      = '0;
    endtask

    // dout after the tick holds the register as it was in the issuing cycle
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.din_addr = a;
        tick();
        d = bus.dout;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        bus.din_val = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rd;
        int          n;
        int          m;
        int          falls;
        int          first_warn;
        logic        any_low;
        logic        seen_fatal;
        logic        prev;
        int          exp_warn_cycle;
        logic [31:0] exp_warn_status;

`ifdef WDT_RECOVERY_PREWARN_EN
        exp_warn_cycle  = 77;          // LOAD=100 -> threshold 25 -> counter 24
        exp_warn_status = 32'h201;
`else
        exp_warn_cycle  = 0;
        exp_warn_status = 32'h001;
`endif

        bus.din_val  = 1'b0;
        bus.din_addr = ADDR_STATUS;
        bus.din      = '0;

        // ---------------- reset values ----------------
        do_reset();
        check_eq("rst_cpu_resetn", 32'(cpu_resetn), 32'd1);
        check_eq("rst_fatal", 32'(fatal), 32'd0);
        check_eq("rst_warn", 32'(warn), 32'd0);
        check_eq("rst_dout", bus.dout, 32'd0);
        bus_read(ADDR_LOAD, rd);
        check_eq("rst_load", rd, 32'd100000);
        bus_read(ADDR_KICK, rd);
        check_eq("rst_counter", rd, 32'd100000);
        bus_read(ADDR_STATUS, rd);
        check_eq("rst_status", rd, 32'd0);

        // ---------------- expiry without kick ----------------
        bus_write(ADDR_LOAD, 32'd10);
        bus_write(ADDR_CTRL, 32'd1);               // now in cycle t+1
        n = 1;
        while (cpu_resetn && n < 50) begin
            tick();
            n++;
        end
        check_eq("expiry_latency", 32'(n), 32'd12);
        m = 0;
        while (!cpu_resetn && m < 50) begin
            tick();
            m++;
        end
        check_eq("recover_window", 32'(m), 32'd16);
        bus_read(ADDR_STATUS, rd);
        check_eq("after_recover_status", rd, 32'h11);

        // ---------------- regular kicks keep it alive ----------------
        do_reset();
        bus_write(ADDR_LOAD, 32'd10);
        bus_write(ADDR_CTRL, 32'd1);
        any_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((i % 8) == 7) bus_write(ADDR_KICK, KICK_KEY);
            else              tick();
            if (!cpu_resetn) any_low = 1'b1;
        end
        check_eq("kick_alive_low_seen", 32'(any_low), 32'd0);
        bus_read(ADDR_STATUS, rd);
        check_eq("kick_alive_status", rd, 32'h01);

        // ---------------- bad kick ----------------
        bus_write(ADDR_KICK, 32'h0000_0000);
        check_eq("bad_kick_cpu_resetn", 32'(cpu_resetn), 32'd0);
        bus_read(ADDR_STATUS, rd);
        check_eq("bad_kick_status", rd, 32'h12);
        m = 0;
        while (!cpu_resetn && m < 50) begin
            tick();
            m++;
        end
        check_eq("bad_kick_rearmed", 32'(cpu_resetn), 32'd1);

        // ---------------- valid kick on the zero cycle ----------------
        // Re-armed with counter=10 in this cycle; reaches 0 ten cycles later
        for (int i = 0; i < 10; i++) tick();
        bus_write(ADDR_KICK, KICK_KEY);
        check_eq("zero_kick_counter_was", bus.dout, 32'd0);
        check_eq("zero_kick_cpu_resetn", 32'(cpu_resetn), 32'd1);
        bus_read(ADDR_KICK, rd);
        check_eq("zero_kick_reload", rd, 32'd10);
        bus_read(ADDR_STATUS, rd);
        check_eq("zero_kick_status", rd, 32'h11);

        // ---------------- pre-expiry warning ----------------
        do_reset();
        bus_write(ADDR_LOAD, 32'd100);
        bus_write(ADDR_CTRL, 32'd1);
        bus.din_addr = ADDR_STATUS;
        first_warn   = 0;
        for (int i = 1; i <= 91; i++) begin
            if (i > 1) tick();
            if (warn && first_warn == 0) first_warn = i;
        end
        check_eq("warn_rise_cycle", 32'(first_warn), 32'(exp_warn_cycle));
        bus_read(ADDR_STATUS, rd);
        check_eq("warn_status", rd, exp_warn_status);
        bus_write(ADDR_KICK, KICK_KEY);
        check_eq("warn_cleared_by_kick", 32'(warn), 32'd0);
        check_eq("warn_cpu_resetn", 32'(cpu_resetn), 32'd1);

        // ---------------- retries exhausted -> FATAL ----------------
        do_reset();
        bus_write(ADDR_LOAD, 32'd5);
        bus_write(ADDR_CTRL, 32'd1);
        n = 1;
        while (cpu_resetn && n < 50) begin
            tick();
            n++;
        end
        check_eq("fatal_first_fall", 32'(n), 32'd7);
        falls      = 1;
        seen_fatal = 1'b0;
        for (int i = 0; i < 200 && !seen_fatal; i++) begin
            prev = cpu_resetn;
            tick();
            if (fatal) seen_fatal = 1'b1;
            else if (prev && !cpu_resetn) falls++;
        end
        check_eq("fatal_reached", 32'(seen_fatal), 32'd1);
        check_eq("fatal_recover_windows", 32'(falls), 32'd3);
        check_eq("fatal_cpu_resetn", 32'(cpu_resetn), 32'd0);
        bus_write(ADDR_CTRL, 32'd0);
        bus_write(ADDR_LOAD, 32'd7);
        tick();
        check_eq("fatal_hold_fatal", 32'(fatal), 32'd1);
        check_eq("fatal_hold_cpu_resetn", 32'(cpu_resetn), 32'd0);
        bus_read(ADDR_LOAD, rd);
        check_eq("fatal_load_ignored", rd, 32'd5);
        bus_read(ADDR_STATUS, rd);
        check_eq("fatal_status", rd, 32'h133);

        // resetn from FATAL restores reset values at the next edge
        resetn = 1'b0;
        tick();
        check_eq("fatal_rst_cpu_resetn", 32'(cpu_resetn), 32'd1);
        check_eq("fatal_rst_fatal", 32'(fatal), 32'd0);
        check_eq("fatal_rst_warn", 32'(warn), 32'd0);
        check_eq("fatal_rst_dout", bus.dout, 32'd0);
        resetn = 1'b1;
        bus_read(ADDR_LOAD, rd);
        check_eq("fatal_rst_load", rd, 32'd100000);
        bus_read(ADDR_STATUS, rd);
        check_eq("fatal_rst_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdt_recovery_ctrl.md
# wdt_recovery_ctrl

Watchdog recovery controller guarding the primary CPU of the SoC. Software arms a loadable down-counter over the peripheral bus and must kick it with a key before it expires. On expiry or a bad kick, the block holds the CPU in reset for a fixed window, then re-arms. After a configurable number of recoveries it latches a fatal state that only system reset clears.

## Interface
Parameters:
- TIMEOUT_W, 24: counter/LOAD width.
- DEFAULT_TIMEOUT, 100000: LOAD and counter value after reset.
- RESET_CYCLES, 16: cycles `cpu_resetn` is held low per recovery; must be at least 1.
- MAX_RETRIES, 3: recoveries allowed before FATAL; range 0..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  system clock.
  - resetn  in  1  synchronous, active-low reset.
- Bus:
  - din_val  in  1  bus write strobe, one cycle per write.
  - din_addr  in  2  register select; also selects the `dout` read source.
  - din  in  32  write data.
  - dout  out  32  registered read data.
- Outputs to the SoC:
  - cpu_resetn  out  1  registered, active-low reset to the guarded CPU.
  - fatal  out  1  retries exhausted.
  - warn  out  1  pre-expiry warning (see Configuration).

## Operation
Registers:
- addr 0, CTRL: bit0 is `enable`.
- addr 1, LOAD: timeout value, [TIMEOUT_W-1:0]. Writing 0 stores 1.
- addr 2, KICK: write only. Reads return the live counter.
- addr 3, STATUS: read only.
  - [1:0] state
  - [7:4] retries
  - [8] fatal
  - [9] warn
- Unused bits read 0.

States (wdt_pkg encoding): DISABLED=0, ARMED=1, RECOVER=2, FATAL=3.
- DISABLED:
  - counter tracks LOAD.
  - CTRL write with bit0=1 → ARMED, counter ← LOAD.
- ARMED:
  - counter decrements by 1 each cycle.
  - KICK write with din==32'h600D_F00D → counter ← LOAD.
  - KICK write with any other value → timeout event.
  - counter==0 with no valid kick → timeout event.
  - CTRL write with bit0=0 → DISABLED.
- Timeout event:
  - if retries==MAX_RETRIES → FATAL; retries unchanged.
  - else retries+1 → RECOVER, reset counter ← RESET_CYCLES-1.
- RECOVER:
  - cpu_resetn=0.
  - CTRL, LOAD and KICK writes are ignored.
  - when the reset counter reaches 0 → ARMED, counter ← LOAD.
- FATAL:
  - cpu_resetn=0 and fatal=1 permanently.
  - all writes are ignored; only resetn exits.

Rules:
- A valid kick in the same cycle that the counter is 0 wins: reload, no timeout.
- LOAD written while ARMED takes effect at the next reload, not on the current count.
- The counter never wraps; it saturates at 0 only transiently, because the timeout fires.
- retries is sticky across DISABLED. It is cleared only by resetn.

## Timing
- Reset values:
  - state DISABLED; LOAD and counter DEFAULT_TIMEOUT; retries 0.
  - cpu_resetn 1, fatal 0, warn 0, dout 0.
- `dout` is registered: it presents the register selected by din_addr at cycle t in cycle t+1.
- Arm timing: CTRL enable written at t → ARMED at t+1 with counter=LOAD=N.
- Expiry with no kick:
  - counter reaches 0 at t+1+N.
  - state is RECOVER and cpu_resetn=0 at t+2+N.
  - cpu_resetn stays low exactly RESET_CYCLES cycles.
  - cpu_resetn returns high in the same cycle state returns to ARMED.
- Bad kick at t → cpu_resetn=0 at t+1.
- A write is applied in the cycle after its strobe; there is no back-pressure.
- resetn asserted mid-recovery or in FATAL → all reset values at the next edge; cpu_resetn=1.

## Configuration
- `WDT_RECOVERY_PREWARN_EN` defined:
  - warn=1 while ARMED and counter < (LOAD>>2).
  - warn clears on a valid kick, on leaving ARMED, or on reset.
  - warn is registered and reflected in STATUS[9].
- Macro not defined: warn is tied 0 and STATUS[9] reads 0. The port remains so that SoC wiring is identical.

## Structure
- Package `wdt_pkg`:
  - state enum
  - register address constants (CTRL, LOAD, KICK, STATUS)
  - KICK_KEY=32'h600D_F00D
  - STATUS bit positions
- Sub-module `wdt_counter`:
  - TIMEOUT_W-bit loadable down-counter.
  - Inputs: load, load_val, dec.
  - Output: zero flag.
- The top holds the FSM, register file, retry counter and reset-window counter.

## Test plan
- LOAD=10, enable, no kick → cpu_resetn low at cycle 12 after the enable write, for exactly 16 cycles; STATUS retries=1, state returns to ARMED.
- LOAD=10, enable, KICK 32'h600D_F00D every 8 cycles for 100 cycles → cpu_resetn stays 1; retries=0.
- ARMED, KICK 32'h0000_0000 → cpu_resetn=0 on the next cycle; retries increments.
- MAX_RETRIES=3, LOAD=5, never kick → three recovery windows, then FATAL on the fourth expiry with fatal=1 and cpu_resetn=0 held. A later CTRL write of 0 has no effect; resetn restores the reset values.
- Valid kick exactly on the cycle the counter reads 0 → no recovery; counter reloads to LOAD.
- With `WDT_RECOVERY_PREWARN_EN`, LOAD=100 → warn rises when counter=24 and clears on the next valid kick. Without the macro, warn stays 0 throughout.
